imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit instruction words stored.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, wait states between request accept and response valid (0..15).
REQ-003 The block SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port req_valid  input  1  fetch request present.
REQ-006 The block SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 The block SHALL have port req_addr  input  32  byte address of requested instruction (the fetch PC).
REQ-008 The block SHALL have port rsp_valid  output  1  response present.
REQ-009 The block SHALL have port rsp_ready  input  1  fetch side accepts response.
REQ-010 The block SHALL have port rsp_instr  output  32  returned instruction word.
REQ-011 The block SHALL have port rsp_error  output  1  response is faulty (misaligned, out of range, or parity).
REQ-012 The block SHALL have port flush  input  1  discard in-flight request (taken branch/jump).
REQ-013 The block SHALL have ports wr_en  input  1, wr_addr  input  32, wr_data  input  32  word-write load port.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-015 In IDLE, req_valid=1 SHALL capture req_addr and go to WAIT with counter=WAIT_CYCLES-1, or to RESP if WAIT_CYCLES=0.
REQ-016 In WAIT, the counter SHALL decrement each cycle; when the counter is 0 the FSM SHALL go to RESP the next cycle; latency from accept to rsp_valid = WAIT_CYCLES+1 cycles.
REQ-017 rsp_instr and rsp_error SHALL be sampled from the array on entry to RESP and held stable while rsp_valid=1 and rsp_ready=0.
REQ-018 In RESP, rsp_valid SHALL be 1; rsp_ready=1 SHALL complete the transfer and return to IDLE the next cycle (no back-to-back accept in the same cycle).
REQ-019 Captured address with addr[1:0] != 0 SHALL give rsp_error=1 and rsp_instr=32'h00000013 (NOP).
REQ-020 Captured address >= DEPTH_WORDS*4 SHALL give rsp_error=1 and rsp_instr=32'h00000013.
REQ-021 Word index SHALL be addr[31:2]; no wrap-around; out-of-range is an error per REQ-020.
REQ-022 flush=1 in WAIT or RESP SHALL return the FSM to IDLE next cycle with rsp_valid=0; flush has priority over rsp_ready.
REQ-023 flush=1 in IDLE SHALL block acceptance of a simultaneous req_valid.
REQ-024 wr_en=1 SHALL write wr_data to word wr_addr[31:2] if in range; out-of-range or misaligned writes SHALL be ignored; writes are accepted in any state.
REQ-025 A write to the captured word in the same cycle as entry to RESP SHALL return the old data (read-before-write); later writes SHALL not alter a held response.

Reset
REQ-026 reset SHALL force state IDLE, counter 0, rsp_valid=0, rsp_error=0, rsp_instr=32'h00000013, req_ready=1 from the next cycle.
REQ-027 reset mid-transaction SHALL drop the pending request without producing a response.
REQ-028 reset SHALL NOT clear array contents.

Configuration
REQ-029 With macro IMEM_PARITY_EN defined, each word SHALL store an even-parity bit computed on write; parity mismatch on read SHALL set rsp_error=1 and keep the stored word on rsp_instr.
REQ-030 Without IMEM_PARITY_EN, no parity storage SHALL exist and rsp_error SHALL reflect only REQ-019/REQ-020.

Verification
REQ-031 Write 0x00500093 at addr 0x10, request 0x10 with WAIT_CYCLES=2 -> rsp_valid in the 3rd cycle after accept, rsp_instr=0x00500093, rsp_error=0.
REQ-032 Request 0x12 -> rsp_error=1, rsp_instr=0x00000013.
REQ-033 Request 0x400 with DEPTH_WORDS=256 -> rsp_error=1, rsp_instr=0x00000013.
REQ-034 Hold rsp_ready=0 for 5 cycles in RESP while writing a new word to the same addr -> rsp_instr unchanged, rsp_valid held, single transfer on rsp_ready=1.
REQ-035 Assert flush one cycle after accept -> rsp_valid never rises, req_ready=1 next cycle; new request 0x14 completes normally.
REQ-036 Assert reset during WAIT -> no response, req_ready=1 next cycle; prior written data still readable.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder: word-addressed fetch array behind a valid/ready
// request/response handshake with programmable wait states. Optional per-word parity via IMEM_PARITY_EN.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_error,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] cap_addr;

  logic [31:0] mem [DEPTH_WORDS];
`ifdef IMEM_PARITY_EN
  logic        mem_par [DEPTH_WORDS];
`endif

  // Aligned and inside the array; the word index is the full addr[31:2], no wrap.
  function automatic logic word_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < 32'(DEPTH_WORDS));
  endfunction

  // {error, instr} for a fetch from address a, using the array contents before this edge's write.
  function automatic logic [32:0] lookup(input logic [31:0] a);
    logic [IDX_W-1:0] idx;
    logic [32:0]      r;
    idx = a[IDX_W+1:2];
    r   = {1'b1, NOP};
    if (word_ok(a)) begin
      r = {1'b0, mem[idx]};
`ifdef IMEM_PARITY_EN
      if ((^mem[idx]) != mem_par[idx]) r[32] = 1'b1;
`endif
    end
    return r;
  endfunction

  logic [IDX_W-1:0] wr_idx;
  assign wr_idx = wr_addr[IDX_W+1:2];

  // Load port: accepted in any state and during reset; array contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && word_ok(wr_addr)) begin
      mem[wr_idx] <= wr_data;
`ifdef IMEM_PARITY_EN
      mem_par[wr_idx] <= ^wr_data;
`endif
    end
  end

  // Request/response FSM; all handshake and response outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_addr  <= 32'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_instr <= NOP;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && !flush) begin
            cap_addr  <= req_addr;
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state                  <= RESP;
              rsp_valid              <= 1'b1;
              {rsp_error, rsp_instr} <= lookup(req_addr);
            end else begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (flush) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
          end else if (cnt == 4'd0) begin
            state                  <= RESP;
            rsp_valid              <= 1'b1;
            {rsp_error, rsp_instr} <= lookup(cap_addr);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // Flush and a completed transfer both retire the response; nothing new is accepted this cycle.
          if (flush || rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= 4'd0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder (DEPTH_WORDS=256, WAIT_CYCLES=2).
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic        rsp_error;
  logic        flush;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  int total = 0;
  int bad   = 0;

  imem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_error (rsp_error),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Full fetch from IDLE: checks latency (3 cycles for WAIT_CYCLES=2), payload, and return to IDLE.
  task automatic fetch(input string tag, input logic [31:0] a,
                       input logic [31:0] exp_instr, input logic exp_err);
    int n;
    req_valid = 1'b1; req_addr = a;
    step();
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 12) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd3);
    chk({tag, "_instr"}, rsp_instr, exp_instr);
    chk({tag, "_error"}, 32'(rsp_error), 32'(exp_err));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    flush = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    @(negedge clk);
    step();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_rsp_instr", rsp_instr, NOP);
    reset = 1'b0;
    step();

    // Basic fetch with per-cycle latency check
    write_word(32'h10, 32'h0050_0093);
    req_valid = 1'b1; req_addr = 32'h10;
    step();
    req_valid = 1'b0;
    chk("acc_req_ready", 32'(req_ready), 32'd0);
    chk("acc_c1_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("acc_c2_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("acc_c3_valid", 32'(rsp_valid), 32'd1);
    chk("acc_c3_instr", rsp_instr, 32'h0050_0093);
    chk("acc_c3_error", 32'(rsp_error), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("acc_done_valid", 32'(rsp_valid), 32'd0);
    chk("acc_done_ready", 32'(req_ready), 32'd1);

    // Error responses and range boundary
    fetch("misaligned", 32'h12, NOP, 1'b1);
    fetch("out_of_range", 32'h400, NOP, 1'b1);
    write_word(32'h3FC, 32'hDEAD_BEEF);
    fetch("last_word", 32'h3FC, 32'hDEAD_BEEF, 1'b0);

    // Bad writes must not alias onto valid words
    write_word(32'h0, 32'h1111_1111);
    write_word(32'h400, 32'hBAD0_0001);
    write_word(32'h12, 32'hBAD0_0002);
    fetch("no_alias_oor", 32'h0, 32'h1111_1111, 1'b0);
    fetch("no_alias_mis", 32'h10, 32'h0050_0093, 1'b0);

    // Held response under backpressure with writes to the same word
    req_valid = 1'b1; req_addr = 32'h10;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("hold_enter", 32'(rsp_valid), 32'd1);
    wr_en = 1'b1; wr_addr = 32'h10; wr_data = 32'hCAFE_F00D;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_instr", rsp_instr, 32'h0050_0093);
    end
    wr_en = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("hold_xfer_drop", 32'(rsp_valid), 32'd0);
    step();
    chk("hold_single_xfer", 32'(rsp_valid), 32'd0);
    fetch("hold_write_landed", 32'h10, 32'hCAFE_F00D, 1'b0);

    // Write on the RESP-entry edge returns old data
    write_word(32'h14, 32'h2222_2222);
    req_valid = 1'b1; req_addr = 32'h14;
    step();
    req_valid = 1'b0;
    step();
    wr_en = 1'b1; wr_addr = 32'h14; wr_data = 32'h3333_3333;
    step();
    wr_en = 1'b0;
    chk("rbw_valid", 32'(rsp_valid), 32'd1);
    chk("rbw_instr", rsp_instr, 32'h2222_2222);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Flush one cycle after accept
    req_valid = 1'b1; req_addr = 32'h10;
    step();
    req_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_ready", 32'(req_ready), 32'd1);
    chk("flush_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("flush_no_rsp", 32'(rsp_valid), 32'd0);
    end
    fetch("after_flush", 32'h14, 32'h3333_3333, 1'b0);

    // Flush in IDLE blocks a simultaneous request
    req_valid = 1'b1; req_addr = 32'h10; flush = 1'b1;
    step();
    req_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_ready", 32'(req_ready), 32'd1);
    step();
    step();
    step();
    chk("idle_flush_no_rsp", 32'(rsp_valid), 32'd0);

    // Flush wins over rsp_ready in RESP
    req_valid = 1'b1; req_addr = 32'h14;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("resp_flush_enter", 32'(rsp_valid), 32'd1);
    flush = 1'b1; rsp_ready = 1'b1;
    step();
    flush = 1'b0; rsp_ready = 1'b0;
    chk("resp_flush_valid", 32'(rsp_valid), 32'd0);
    chk("resp_flush_ready", 32'(req_ready), 32'd1);

    // Reset during WAIT drops the request but keeps the array
    req_valid = 1'b1; req_addr = 32'h10;
    step();
    req_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("wait_rst_ready", 32'(req_ready), 32'd1);
    chk("wait_rst_valid", 32'(rsp_valid), 32'd0);
    chk("wait_rst_instr", rsp_instr, NOP);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wait_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    fetch("after_reset", 32'h10, 32'hCAFE_F00D, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
